// File: rtl/pool_stream_serializer_if.sv
// rtl/pool_stream_serializer_if.sv - frame capture and raster stream signals for pool_stream_serializer
//
// Purpose: bundles the frame-capture handshake (in_frame/in_valid/in_ready)
// and the raster output stream (out_* plus done) of the serializer.
// Modports:
//   slave  - the serializer: takes in_frame/in_valid/out_ready and
//            drives in_ready, the out_* beat fields and done.
//   master - the surrounding logic: the pooling stage that offers frames
//            and the consumer that accepts beats.
// Derived widths follow the pooling geometry, so that both sides agree on
// the frame shape.

interface pool_stream_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_SIZE   = 4,
    parameter int POOL_SIZE  = 2,
    parameter int STRIDE     = 2,
    parameter int PADDING    = 1,
    parameter int CH_IN      = 3
);
    localparam int OUT_SIZE = (IMG_SIZE + 2*PADDING - POOL_SIZE)/STRIDE + 1;
    localparam int CW       = (CH_IN > 1) ? $clog2(CH_IN) : 1;
    localparam int SW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    logic [CH_IN-1:0][OUT_SIZE-1:0][OUT_SIZE-1:0][DATA_WIDTH-1:0] in_frame;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CW-1:0]         out_ch;
    logic [SW-1:0]         out_row;
    logic [SW-1:0]         out_col;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;
    logic                  done;

    modport slave (
        input  in_frame, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_row, out_col,
               out_last, out_valid, done
    );

    modport master (
        output in_frame, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_row, out_col,
               out_last, out_valid, done
    );
endinterface

// File: rtl/pool_stream_serializer.sv
// rtl/pool_stream_serializer.sv - captures a pooled feature map and streams it channel/row/column-major
//
// Purpose: takes one complete pooled map in a single cycle into a frame
// buffer, then emits it one element per beat under valid/ready, tagging
// every beat with its (channel, row, column) and marking the final element.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - pool_stream_serializer_if.slave: in_frame/in_valid/in_ready
//          capture handshake, out_data/out_ch/out_row/out_col/out_last/
//          out_valid/out_ready stream, done pulse after the last beat.

module pool_stream_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_SIZE   = 4,
    parameter int POOL_SIZE  = 2,
    parameter int STRIDE     = 2,
    parameter int PADDING    = 1,
    parameter int CH_IN      = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    pool_stream_serializer_if.slave bus
);
    localparam int OUT_SIZE = (IMG_SIZE + 2*PADDING - POOL_SIZE)/STRIDE + 1;
    localparam int CW       = (CH_IN > 1) ? $clog2(CH_IN) : 1;
    localparam int SW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(CH_IN - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OUT_SIZE - 1);

    typedef logic [CH_IN-1:0][OUT_SIZE-1:0][OUT_SIZE-1:0][DATA_WIDTH-1:0] frame_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [SW-1:0] r_q, r_d;
    logic [SW-1:0] k_q, k_d;
    logic          done_q, done_d;
    frame_t        buf_q, buf_d;

    logic streaming;
    logic is_last;

    assign streaming = (state_q == STREAM);
    assign is_last   = streaming && (c_q == C_LAST) && (r_q == S_LAST) && (k_q == S_LAST);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        k_d     = k_q;
        done_d  = 1'b0;
        buf_d   = buf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    buf_d   = bus.in_frame;
                    c_d     = '0;
                    r_d     = '0;
                    k_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // out_valid is constantly high here, so out_ready alone is the handshake.
                if (bus.out_ready) begin
                    if (is_last) begin
                        c_d     = '0;
                        r_d     = '0;
                        k_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (k_q == S_LAST) begin
                        k_d = '0;
                        if (r_q == S_LAST) begin
                            r_d = '0;
                            c_d = c_q + CW'(1);
                        end else begin
                            r_d = r_q + SW'(1);
                        end
                    end else begin
                        k_d = k_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            r_q     <= r_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    // The buffer needs no reset: it is only observed while streaming, and
    // every entry into STREAM reloads it.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = streaming;
    // Gated so that idle/reset shows zero rather than stale buffer contents.
    assign bus.out_data  = streaming ? buf_q[c_q][r_q][k_q] : '0;
    assign bus.out_ch    = c_q;
    assign bus.out_row   = r_q;
    assign bus.out_col   = k_q;
    assign bus.out_last  = is_last;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_pool_stream_serializer.sv
// tb/tb_pool_stream_serializer.sv - directed self-checking bench for pool_stream_serializer

module tb_pool_stream_serializer;
    localparam int DW     = 8;
    localparam int CH     = 3;
    localparam int OS     = 3;
    localparam int NBEATS = CH*OS*OS;

    typedef logic [CH-1:0][OS-1:0][OS-1:0][DW-1:0] frame_t;

    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    frame_t fa, fff, fb;

    pool_stream_serializer_if #(
        .DATA_WIDTH(8), .IMG_SIZE(4), .POOL_SIZE(2),
        .STRIDE(2), .PADDING(1), .CH_IN(3)
    ) bus ();

    pool_stream_serializer #(
        .DATA_WIDTH(8), .IMG_SIZE(4), .POOL_SIZE(2),
        .STRIDE(2), .PADDING(1), .CH_IN(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumes nbeats beats starting at element (0,0,0); called one cycle
    // after the capture edge. With random_ready the acceptance pattern
    // begins 1,0,0,1 and stalls are checked for stable outputs.
    task automatic stream_frame(input frame_t exp, input bit random_ready, input int nbeats);
        int          i;
        int          cyc;
        int          c, r, k;
        bit          stalled;
        logic [15:0] pat;
        logic [7:0]  pd;
        logic [1:0]  pc, pr, pk;
        logic        pl;
        i       = 0;
        cyc     = 0;
        stalled = 1'b0;
        pat     = 16'b0110_1011_0100_1001;
        pd = '0; pc = '0; pr = '0; pk = '0; pl = 1'b0;
        while (i < nbeats && cyc < 400) begin
            c = i / (OS*OS);
            r = (i / OS) % OS;
            k = i % OS;
            check("out_valid", bus.out_valid, 1);
            check("in_ready_busy", bus.in_ready, 0);
            check("done_busy", bus.done, 0);
            if (stalled) begin
                check("hold_data", bus.out_data, pd);
                check("hold_ch", bus.out_ch, pc);
                check("hold_row", bus.out_row, pr);
                check("hold_col", bus.out_col, pk);
                check("hold_last", bus.out_last, pl);
            end
            check("data", bus.out_data, exp[c][r][k]);
            check("ch", bus.out_ch, c);
            check("row", bus.out_row, r);
            check("col", bus.out_col, k);
            check("last", bus.out_last, (i == NBEATS-1) ? 1 : 0);
            bus.out_ready = random_ready ? pat[cyc % 16] : 1'b1;
            pd = bus.out_data; pc = bus.out_ch; pr = bus.out_row;
            pk = bus.out_col;  pl = bus.out_last;
            stalled = !bus.out_ready;
            if (bus.out_ready) i++;
            cyc++;
            tick();
        end
        check("beats_accepted", i, nbeats);
        if (nbeats == NBEATS) begin
            check("done_pulse", bus.done, 1);
            check("idle_out_valid", bus.out_valid, 0);
            check("idle_in_ready", bus.in_ready, 1);
            check("idle_last", bus.out_last, 0);
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < OS; r++)
                for (int k = 0; k < OS; k++) begin
                    fa[c][r][k]  = DW'(9*c + 3*r + k + 1);
                    fff[c][r][k] = 8'hFF;
                    fb[c][r][k]  = ((c + r + k) % 2 == 1) ? 8'd255 : 8'd0;
                end

        rst           = 1'b1;
        bus.in_frame  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_done", bus.done, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_ch", bus.out_ch, 0);
        check("rst_row", bus.out_row, 0);
        check("rst_col", bus.out_col, 0);
        rst = 1'b0;

        // ready held high: 27 consecutive beats 1..27
        bus.out_ready = 1'b1;
        bus.in_frame  = fa;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        stream_frame(fa, 1'b0, NBEATS);
        tick();
        check("done_one_cycle", bus.done, 0);
        check("stay_idle", bus.out_valid, 0);

        // pseudo-random backpressure
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        stream_frame(fa, 1'b1, NBEATS);
        tick();
        check("done_one_cycle_bp", bus.done, 0);

        // in_valid held with a different frame while streaming
        bus.in_frame = fa;
        bus.in_valid = 1'b1;
        tick();
        bus.in_frame = fff;
        stream_frame(fa, 1'b0, NBEATS);
        tick();
        bus.in_valid = 1'b0;
        stream_frame(fff, 1'b0, NBEATS);
        tick();
        check("idle_after_ff", bus.out_valid, 0);

        // back-to-back frames, boundary values first
        bus.in_frame = fb;
        bus.in_valid = 1'b1;
        tick();
        bus.in_frame = fa;
        stream_frame(fb, 1'b0, NBEATS);
        tick();
        bus.in_valid = 1'b0;
        stream_frame(fa, 1'b1, NBEATS);
        tick();

        // reset after 10 accepted beats
        bus.in_frame = fa;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        stream_frame(fa, 1'b0, 10);
        rst = 1'b1;
        tick();
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_data", bus.out_data, 0);
        rst = 1'b0;
        tick();
        check("post_rst_done", bus.done, 0);
        check("post_rst_out_valid", bus.out_valid, 0);
        bus.in_frame = fb;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        stream_frame(fb, 1'b1, NBEATS);
        tick();
        check("final_idle", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
